// File: rtl/fp_mult_pipe_if.sv
// ============================================================================
// Module   : fp_mult_pipe_if
// Desc     : Operand/result handshake bundle for fp_mult_pipe.
//            The flags signal exists only when FP_MULT_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_mult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int c_W = 1 + EXP_W + MAN_W;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] p;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]     flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, flags
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, flags
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fp_mult_pipe.sv
// ============================================================================
// Module   : fp_mult_pipe
// Desc     : Pipelined floating-point multiplier (RNE, flush-to-zero) with
//            valid/ready flow control. FP_MULT_FLAGS_EN adds the flags output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mult_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fp_mult_pipe_if.slave bus
);
    localparam int c_W  = 1 + EXP_W + MAN_W;
    localparam int c_MW = MAN_W + 1;
    localparam int c_PW = 2 * c_MW;
    localparam int c_XW = EXP_W + 2;

    localparam logic signed [c_XW-1:0] c_BIAS  = c_XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_XW-1:0] c_EMAX  = c_XW'((1 << EXP_W) - 1);
    localparam logic signed [c_XW-1:0] c_EZERO = '0;
    localparam logic [EXP_W-1:0]       c_EXP_ONES = '1;
    localparam logic [EXP_W-1:0]       c_EXP_ZERO = '0;
    localparam logic [MAN_W-1:0]       c_MAN_ZERO = '0;
    localparam logic [MAN_W-1:0]       c_MAN_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [1:0] c_CLS_NORM = 2'd0;
    localparam logic [1:0] c_CLS_NAN  = 2'd1;
    localparam logic [1:0] c_CLS_INF  = 2'd2;
    localparam logic [1:0] c_CLS_ZERO = 2'd3;

    // Single global enable: every stage advances or holds together.
    logic w_en;
    logic r_out_valid;
    assign w_en          = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;

    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    assign {w_sa, w_ea, w_fa} = bus.a;
    assign {w_sb, w_eb, w_fb} = bus.b;

    logic w_a_emax, w_a_nan, w_a_inf, w_a_zero;
    logic w_b_emax, w_b_nan, w_b_inf, w_b_zero;
    assign w_a_emax = (w_ea == c_EXP_ONES);
    assign w_b_emax = (w_eb == c_EXP_ONES);
    assign w_a_nan  = w_a_emax && (w_fa != c_MAN_ZERO);
    assign w_b_nan  = w_b_emax && (w_fb != c_MAN_ZERO);
    assign w_a_inf  = w_a_emax && (w_fa == c_MAN_ZERO);
    assign w_b_inf  = w_b_emax && (w_fb == c_MAN_ZERO);
    assign w_a_zero = (w_ea == c_EXP_ZERO);
    assign w_b_zero = (w_eb == c_EXP_ZERO);

    // Subnormals share the zero class, so inf*subnormal is also invalid.
    logic [1:0] w_cls;
    always_comb begin
        w_cls = c_CLS_NORM;
        if (w_a_nan || w_b_nan)
            w_cls = c_CLS_NAN;
        else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_cls = c_CLS_NAN;
        else if (w_a_inf || w_b_inf)
            w_cls = c_CLS_INF;
        else if (w_a_zero || w_b_zero)
            w_cls = c_CLS_ZERO;
    end

    logic signed [c_XW-1:0] w_exp;
    assign w_exp = $signed(c_XW'(w_ea)) + $signed(c_XW'(w_eb)) - c_BIAS;

`ifdef FP_MULT_FLAGS_EN
    logic w_inv;
    assign w_inv = (w_a_nan || w_b_nan)
                 ? ((w_a_nan && !w_fa[MAN_W-1]) || (w_b_nan && !w_fb[MAN_W-1]))
                 : ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero));
`endif

    logic                   r1_valid;
    logic                   r1_sign;
    logic signed [c_XW-1:0] r1_exp;
    logic [c_MW-1:0]        r1_ma, r1_mb;
    logic [1:0]             r1_cls;
`ifdef FP_MULT_FLAGS_EN
    logic                   r1_inv;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r1_valid <= 1'b0;
        else if (w_en)
            r1_valid <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_sign <= w_sa ^ w_sb;
            r1_exp  <= w_exp;
            r1_ma   <= {1'b1, w_fa};
            r1_mb   <= {1'b1, w_fb};
            r1_cls  <= w_cls;
`ifdef FP_MULT_FLAGS_EN
            r1_inv  <= w_inv;
`endif
        end
    end

    logic [c_PW-1:0] w_prod1;
    assign w_prod1 = c_PW'(r1_ma) * c_PW'(r1_mb);

    logic                   w_l_valid;
    logic                   w_l_sign;
    logic signed [c_XW-1:0] w_l_exp;
    logic [c_PW-1:0]        w_l_prod;
    logic [1:0]             w_l_cls;
`ifdef FP_MULT_FLAGS_EN
    logic                   w_l_inv;
`endif

    generate
        if (STAGES == 2) begin : g_direct
            assign w_l_valid = r1_valid;
            assign w_l_sign  = r1_sign;
            assign w_l_exp   = r1_exp;
            assign w_l_prod  = w_prod1;
            assign w_l_cls   = r1_cls;
`ifdef FP_MULT_FLAGS_EN
            assign w_l_inv   = r1_inv;
`endif
        end else begin : g_mid
            // Entry 0 registers the product; later entries are pure delay.
            localparam int c_N = STAGES - 2;
            logic                   r_v [c_N];
            logic                   r_s [c_N];
            logic signed [c_XW-1:0] r_e [c_N];
            logic [c_PW-1:0]        r_pr[c_N];
            logic [1:0]             r_c [c_N];
`ifdef FP_MULT_FLAGS_EN
            logic                   r_i [c_N];
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c_N; i++) r_v[i] <= 1'b0;
                end else if (w_en) begin
                    r_v[0] <= r1_valid;
                    for (int i = 1; i < c_N; i++) r_v[i] <= r_v[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_s[0]  <= r1_sign;
                    r_e[0]  <= r1_exp;
                    r_pr[0] <= w_prod1;
                    r_c[0]  <= r1_cls;
`ifdef FP_MULT_FLAGS_EN
                    r_i[0]  <= r1_inv;
`endif
                    for (int i = 1; i < c_N; i++) begin
                        r_s[i]  <= r_s[i-1];
                        r_e[i]  <= r_e[i-1];
                        r_pr[i] <= r_pr[i-1];
                        r_c[i]  <= r_c[i-1];
`ifdef FP_MULT_FLAGS_EN
                        r_i[i]  <= r_i[i-1];
`endif
                    end
                end
            end

            assign w_l_valid = r_v[c_N-1];
            assign w_l_sign  = r_s[c_N-1];
            assign w_l_exp   = r_e[c_N-1];
            assign w_l_prod  = r_pr[c_N-1];
            assign w_l_cls   = r_c[c_N-1];
`ifdef FP_MULT_FLAGS_EN
            assign w_l_inv   = r_i[c_N-1];
`endif
        end
    endgenerate

    // Fraction below the leading one, left-aligned whichever bit it sits in.
    logic [c_PW-2:0]        w_frac;
    logic signed [c_XW-1:0] w_exp_n, w_exp_f;
    logic [MAN_W-1:0]       w_man;
    logic                   w_g, w_r, w_st, w_rup;
    logic [MAN_W:0]         w_man_r;
    logic                   w_ovf, w_unf;

    assign w_frac  = w_l_prod[c_PW-1] ? w_l_prod[c_PW-2:0] : {w_l_prod[c_PW-3:0], 1'b0};
    assign w_exp_n = w_l_exp + $signed(c_XW'(w_l_prod[c_PW-1]));
    assign w_man   = w_frac[c_PW-2 -: MAN_W];
    assign w_g     = w_frac[MAN_W];
    assign w_r     = w_frac[MAN_W-1];
    assign w_st    = |w_frac[MAN_W-2:0];
    assign w_rup   = w_g && (w_r || w_st || w_man[0]);
    assign w_man_r = {1'b0, w_man} + (MAN_W+1)'(w_rup);
    assign w_exp_f = w_exp_n + $signed(c_XW'(w_man_r[MAN_W]));
    assign w_ovf   = (w_exp_f >= c_EMAX);
    assign w_unf   = (w_exp_f <= c_EZERO);

    logic [c_W-1:0] w_p;
    always_comb begin
        w_p = {w_l_sign, w_exp_f[EXP_W-1:0], w_man_r[MAN_W-1:0]};
        case (w_l_cls)
            c_CLS_NAN:  w_p = {1'b0, c_EXP_ONES, c_MAN_QNAN};
            c_CLS_INF:  w_p = {w_l_sign, c_EXP_ONES, c_MAN_ZERO};
            c_CLS_ZERO: w_p = {w_l_sign, c_EXP_ZERO, c_MAN_ZERO};
            default: begin
                if (w_ovf)
                    w_p = {w_l_sign, c_EXP_ONES, c_MAN_ZERO};
                else if (w_unf)
                    w_p = {w_l_sign, c_EXP_ZERO, c_MAN_ZERO};
            end
        endcase
    end

    logic [c_W-1:0] r_p;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_p         <= '0;
        end else if (w_en) begin
            r_out_valid <= w_l_valid;
            r_p         <= w_p;
        end
    end
    assign bus.p = r_p;

`ifdef FP_MULT_FLAGS_EN
    logic [3:0] w_flags;
    logic [3:0] r_flags;
    always_comb begin
        w_flags = 4'b0000;
        case (w_l_cls)
            c_CLS_NAN:  w_flags = {w_l_inv, 3'b000};
            c_CLS_NORM: w_flags = {1'b0, w_ovf, w_unf, w_ovf || w_unf || w_g || w_r || w_st};
            default:    w_flags = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_flags <= 4'b0000;
        else if (w_en)
            r_flags <= w_flags;
    end
    assign bus.flags = r_flags;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
// ============================================================================
// Module   : tb_fp_mult_pipe
// Desc     : Directed self-checking bench for fp_mult_pipe (FP32 and FP16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mult_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(3)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one op into an idle pipeline; returns the result and accept-to-valid latency.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        bus.a = op_a; bus.b = op_b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.p !== 32'h0) begin n_fail++; $display("FAIL reset_p got %h want 00000000", bus.p); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16 got %b want 0", bus16.out_valid); end
`ifdef FP_MULT_FLAGS_EN
        n_checks++; if (bus.flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", bus.flags); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat;
        run_op(32'h3F800000, 32'h40000000, res, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
        n_checks++; if (res !== 32'h40000000) begin n_fail++; $display("FAIL basic_p got %h want 40000000", res); end
`ifdef FP_MULT_FLAGS_EN
        n_checks++; if (bus.flags !== 4'h0) begin n_fail++; $display("FAIL basic_flags got %b want 0000", bus.flags); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vp [3];
        va = '{32'hC0000000, 32'h40490FDB, 32'hBF800000};
        vb = '{32'h40000000, 32'h40000000, 32'h3F800000};
        vp = '{32'hC0800000, 32'h40C90FDB, 32'hBF800000};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus.in_valid = (c < 3);
            if (c < 3) begin
                bus.a = va[c];
                bus.b = vb[c];
            end
            n_checks++;
            if (bus.out_valid !== (c >= 3 && c < 6)) begin
                n_fail++; $display("FAIL b2b_valid cycle %0d got %b want %b", c, bus.out_valid, (c >= 3 && c < 6));
            end
            if (c >= 3 && c < 6) begin
                n_checks++;
                if (bus.p !== vp[c-3]) begin n_fail++; $display("FAIL b2b_p idx %0d got %h want %h", c - 3, bus.p, vp[c-3]); end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_specials();
        logic [31:0] sa [9];
        logic [31:0] sb [9];
        logic [31:0] sp [9];
        logic [31:0] res;
        int lat;
`ifdef FP_MULT_FLAGS_EN
        logic [3:0] sf [9];
        sf = '{4'b1000, 4'b0101, 4'b0011, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
`endif
        sa = '{32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h7FC00000, 32'h7F800001,
               32'hFF800000, 32'h80000000, 32'h00000001, 32'h3F800001};
        sb = '{32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3F800000,
               32'h40000000, 32'h40000000, 32'h40000000, 32'h3F800001};
        sp = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
               32'hFF800000, 32'h80000000, 32'h00000000, 32'h3F800002};
        for (int k = 0; k < 9; k++) begin
            run_op(sa[k], sb[k], res, lat);
            n_checks++;
            if (res !== sp[k] || lat !== 3) begin
                n_fail++; $display("FAIL special_%0d got %h lat %0d want %h lat 3", k, res, lat, sp[k]);
            end
`ifdef FP_MULT_FLAGS_EN
            n_checks++;
            if (bus.flags !== sf[k]) begin n_fail++; $display("FAIL special_flags_%0d got %b want %b", k, bus.flags, sf[k]); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] want;
        bit has_held;
        int sent, recv, rdy_low;
        sent = 0; recv = 0; rdy_low = 0; has_held = 0; held = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(posedge clk); #1;
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            bus.in_valid  = (sent < 8);
            bus.a = 32'h40000000;
            bus.b = 32'h3F800000 + 32'(sent) * 32'h00012345;
            #1;
            if (bus.out_valid) begin
                if (!bus.out_ready) begin
                    if (has_held) begin
                        n_checks++;
                        if (bus.p !== held) begin n_fail++; $display("FAIL bp_hold cycle %0d got %h want %h", cyc, bus.p, held); end
                    end
                    held = bus.p;
                    has_held = 1;
                end else begin
                    has_held = 0;
                    want = 32'h3F800000 + 32'(recv) * 32'h00012345 + 32'h00800000;
                    n_checks++;
                    if (bus.p !== want) begin n_fail++; $display("FAIL bp_order idx %0d got %h want %h", recv, bus.p, want); end
                    recv++;
                end
            end
            if (!bus.in_ready) rdy_low++;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++; if (recv !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", recv); end
        n_checks++; if (rdy_low < 5) begin n_fail++; $display("FAIL bp_in_ready_low got %0d cycles want >=5", rdy_low); end
    endtask

    task automatic test_reset_flush();
        logic [31:0] res;
        int lat, seen;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40000000;
        @(posedge clk); #1;
        bus.a = 32'h40000000; bus.b = 32'h40000000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.p !== 32'h0) begin n_fail++; $display("FAIL flush_p got %h want 00000000", bus.p); end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_ghost got %0d outputs want 0", seen); end
        run_op(32'h40400000, 32'h40000000, res, lat);
        n_checks++;
        if (res !== 32'h40C00000 || lat !== 3) begin
            n_fail++; $display("FAIL flush_next got %h lat %0d want 40C00000 lat 3", res, lat);
        end
    endtask

    task automatic test_fp16();
        logic [15:0] fa [2];
        logic [15:0] fb [2];
        logic [15:0] fp [2];
        int lat;
`ifdef FP_MULT_FLAGS_EN
        logic [3:0] ff [2];
        ff = '{4'b0000, 4'b0001};
`endif
        fa = '{16'h3C00, 16'h3555};
        fb = '{16'h4000, 16'h3555};
        fp = '{16'h4000, 16'h2F1C};
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus16.a = fa[k]; bus16.b = fb[k]; bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
            @(posedge clk); #1;
            bus16.in_valid = 1'b0;
            lat = 1;
            while (!bus16.out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            n_checks++;
            if (bus16.p !== fp[k] || lat !== 3) begin
                n_fail++; $display("FAIL fp16_%0d got %h lat %0d want %h lat 3", k, bus16.p, lat, fp[k]);
            end
`ifdef FP_MULT_FLAGS_EN
            n_checks++;
            if (bus16.flags !== ff[k]) begin n_fail++; $display("FAIL fp16_flags_%0d got %b want %b", k, bus16.flags, ff[k]); end
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;   bus.a = '0;   bus.b = '0;   bus.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_specials();
        test_backpressure();
        test_reset_flush();
        test_fp16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
